// File: rtl/enemy_shooter.sv
// enemy_shooter: enemy return fire aimed at the player ship.
//
// An LFSR picks the firing column. After a cooldown, the block launches one
// bullet from the enemy the formation reports for that column. The bullet
// then drops step_p pixels per frame and is tested against the player box
// on every frame.
//
// Ports:
//   clk_i, reset_ni         clock, asynchronous active-low reset
//   frame_i                 one-cycle frame strobe
//   enable_i                game running; low freezes all state except the LFSR
//   clear_i                 synchronous drop of the bullet and cooldown restart
//   shooter_valid_i         formation has a live enemy in column col_sel_o
//   shooter_left_i/bot_i    gun x / bottom y of that enemy
//   player_left_i/right_i   player horizontal extent
//   col_sel_o               requested firing column (LFSR value, never 0)
//   hit_o                   one-cycle pulse, player hit
//   bullet_o                bullet visible
//   bullet_*_o              bullet box and colour
//   state_o                 present one-hot state, for debug
module enemy_shooter #(
    parameter logic [11:0] color_p         = {4'hE, 4'h5, 4'h5},
    parameter logic [9:0]  step_p          = 10'd4,
    parameter logic [7:0]  cooldown_p      = 8'd60,
    parameter logic [9:0]  bullet_w_p      = 10'd6,
    parameter logic [9:0]  bullet_h_p      = 10'd10,
    parameter logic [9:0]  player_top_p    = 10'd400,
    parameter logic [9:0]  player_bot_p    = 10'd420,
    parameter logic [9:0]  bottom_border_p = 10'd470
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       frame_i,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic       shooter_valid_i,
    input  logic [9:0] shooter_left_i,
    input  logic [9:0] shooter_bot_i,
    input  logic [9:0] player_left_i,
    input  logic [9:0] player_right_i,
    output logic [3:0] col_sel_o,
    output logic       hit_o,
    output logic       bullet_o,
    output logic [9:0] bullet_left_o,
    output logic [9:0] bullet_right_o,
    output logic [9:0] bullet_top_o,
    output logic [9:0] bullet_bot_o,
    output logic [3:0] bullet_red_o,
    output logic [3:0] bullet_green_o,
    output logic [3:0] bullet_blue_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        StCooldown = 3'b001,
        StArmed    = 3'b010,
        StFlying   = 3'b100
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  left_q, left_d;
    logic [9:0]  top_q, top_d;
    logic        hit_q, hit_d;
    logic [3:0]  lfsr_q, lfsr_d;

    logic        tick;
    logic [9:0]  right;
    logic [9:0]  bot;
    logic        collide;
    logic [10:0] top_stepped;
    logic        at_border;

    assign tick  = frame_i & enable_i;
    assign right = left_q + bullet_w_p;
    assign bot   = top_q + bullet_h_p;

    assign collide = (right > player_left_i) && (left_q < player_right_i) &&
                     (bot >= player_top_p) && (top_q <= player_bot_p);

    // 11-bit sum so a bullet near the bottom of the range cannot wrap past the border.
    assign top_stepped = {1'b0, top_q} + {1'b0, step_p};
    assign at_border   = top_stepped >= {1'b0, bottom_border_p};

    // x^4 + x^3 + 1; runs on every frame so the column keeps changing while frozen.
    assign lfsr_d = frame_i ? {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]} : lfsr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        top_d   = top_q;
        hit_d   = 1'b0;
        if (clear_i) begin
            state_d = StCooldown;
            cnt_d   = cooldown_p;
        end else begin
            unique case (state_q)
                StCooldown: begin
                    if (tick) begin
                        if (cnt_q == 8'd0) begin
                            state_d = StArmed;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                StArmed: begin
                    if (tick && shooter_valid_i) begin
                        left_d  = shooter_left_i;
                        top_d   = shooter_bot_i;
                        state_d = StFlying;
                    end
                end
                StFlying: begin
                    if (tick) begin
                        if (collide) begin
                            hit_d   = 1'b1;
                            state_d = StCooldown;
                            cnt_d   = cooldown_p;
                        end else if (at_border) begin
                            state_d = StCooldown;
                            cnt_d   = cooldown_p;
                        end else begin
                            top_d = top_stepped[9:0];
                        end
                    end
                end
                default: begin
                    state_d = StCooldown;
                    cnt_d   = cooldown_p;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StCooldown;
            cnt_q   <= cooldown_p;
            left_q  <= 10'd0;
            top_q   <= 10'd0;
            hit_q   <= 1'b0;
            lfsr_q  <= 4'b1001;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            top_q   <= top_d;
            hit_q   <= hit_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign col_sel_o      = lfsr_q;
    assign hit_o          = hit_q;
    assign bullet_o       = (state_q == StFlying);
    assign bullet_left_o  = left_q;
    assign bullet_right_o = right;
    assign bullet_top_o   = top_q;
    assign bullet_bot_o   = bot;
    assign bullet_red_o   = color_p[11:8];
    assign bullet_green_o = color_p[7:4];
    assign bullet_blue_o  = color_p[3:0];
    assign state_o        = state_q;

endmodule
